// File: rtl/rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter_pkg
//  Purpose  : Shared widths, destination-field layout and FSM encodings for
//             the round-robin FIFO arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package rr_arbiter_pkg;

    // Default word width and queue count.
    localparam int RR_DATA_W = 6;
    localparam int RR_NUM_Q  = 4;

    // Destination field occupies the top DEST_W bits of every word.
    localparam int DEST_W = 2;

    // Arbiter FSM encodings.
    localparam int         STATE_W   = 2;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;

    // Width of a queue index; never zero so single-queue builds still elaborate.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bit position of the destination field's least significant bit.
    function automatic int dest_lsb(input int data_w);
        return data_w - DEST_W;
    endfunction

endpackage : rr_arbiter_pkg
`default_nettype wire

// File: rtl/rr_arbiter_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin search. Scans ptr+1, ptr+2, ...
//             modulo N and grants the first requesting lane.
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick
    import rr_arbiter_pkg::*;
#(
    parameter int N     = RR_NUM_Q,
    parameter int PTR_W = ptr_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic             gnt_valid_o
);

    // First requester after the pointer wins; the pointer lane itself is last.
    always_comb begin
        gnt_o       = '0;
        gnt_valid_o = 1'b0;
        for (int i = 1; i <= N; i++) begin
            int idx;
            idx = (int'(ptr_i) + i) % N;
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_o[idx]  = 1'b1;
                gnt_valid_o = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Pops words round-robin from NUM_Q upstream FIFOs and writes each
//             to the downstream FIFO named by its destination field. Pops are
//             combinational; data returns one cycle later and is registered
//             onto the shared output bus, so a word appears two cycles after
//             its pop strobe.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int DATA_W = RR_DATA_W,
    parameter int NUM_Q  = RR_NUM_Q
) (
    input  logic                    clk,
    input  logic                    RESET_L,
    input  logic [NUM_Q-1:0]        in_empty,
    input  logic [NUM_Q*DATA_W-1:0] in_data,
    input  logic [NUM_Q-1:0]        in_valid,
    output logic [NUM_Q-1:0]        in_rd,
    input  logic [NUM_Q-1:0]        out_pause,
    input  logic [NUM_Q-1:0]        out_full,
    output logic [NUM_Q-1:0]        out_wr,
    output logic [DATA_W-1:0]       out_data,
    output logic                    err,
    output logic                    idle
);

    localparam int               PTR_W = ptr_width(NUM_Q);
    localparam logic [NUM_Q-1:0] ONE   = NUM_Q'(1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               pend_q, pend_d;
    logic [PTR_W-1:0]   pend_idx_q, pend_idx_d;
    logic [NUM_Q-1:0]   out_wr_q, out_wr_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               err_q, err_d;

    logic [NUM_Q-1:0]   req;
    logic [NUM_Q-1:0]   gnt;
    logic               gnt_valid;
    logic [PTR_W-1:0]   gnt_idx;
    logic               pop;
    logic               any_req;
    logic               any_pause;
    logic               all_empty;
    logic [NUM_Q-1:0]   pend_oh;
    logic [DATA_W-1:0]  pend_word;
    logic [DEST_W-1:0]  dest;
    logic [NUM_Q-1:0]   dest_oh;
    logic               take;
    logic               miss;
    logic               stray;

    assign req       = ~in_empty;
    assign any_req   = |req;
    assign all_empty = &in_empty;
    assign any_pause = |out_pause;

    rr_pick #(
        .N     (NUM_Q),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i       (req),
        .ptr_i       (ptr_q),
        .gnt_o       (gnt),
        .gnt_valid_o (gnt_valid)
    );

    // Encode the one-hot grant back to a queue index for ptr and pending.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (gnt[i]) begin
                gnt_idx = PTR_W'(i);
            end
        end
    end

    // Pop only while running and no downstream FIFO asks for a pause; the
    // pause gate is combinational so the strobe drops in the same cycle.
    assign pop   = (state_q == ST_RUN) && !any_pause && gnt_valid;
    assign in_rd = pop ? gnt : '0;

    assign ptr_d      = pop ? gnt_idx : ptr_q;
    assign pend_d     = pop;
    assign pend_idx_d = pop ? gnt_idx : pend_idx_q;

    // Word returned for the pending pop, and where it is headed.
    assign pend_oh   = ONE << pend_idx_q;
    assign pend_word = in_data[pend_idx_q*DATA_W +: DATA_W];
    assign dest      = pend_word[dest_lsb(DATA_W) +: DEST_W];
    assign dest_oh   = ONE << dest;

    // A pending pop is honoured only by its own lane's valid; any other
    // valid, or a missing one, is a protocol fault and the word is lost.
    assign take  = pend_q && in_valid[pend_idx_q];
    assign miss  = pend_q && !in_valid[pend_idx_q];
    assign stray = |(in_valid & ~(pend_q ? pend_oh : '0));

    // Capture path: forward to the destination unless it is full; err is sticky.
    always_comb begin
        out_wr_d   = '0;
        out_data_d = out_data_q;
        err_d      = err_q | miss | stray;
        if (take) begin
            if (out_full[dest]) begin
                err_d = 1'b1;
            end else begin
                out_wr_d   = dest_oh;
                out_data_d = pend_word;
            end
        end
    end

    // Arbiter FSM: leave IDLE once work exists, park in PAUSED on backpressure.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req && !any_pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (any_pause) begin
                    state_d = ST_PAUSED;
                end else if (all_empty && !pend_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAUSED: begin
                if (all_empty && !pend_q) begin
                    state_d = ST_IDLE;
                end else if (!any_pause && any_req) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer, pending slot and output registers; reset drops any
    // in-flight word and aims the first grant at queue 0.
    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q    <= ST_IDLE;
            ptr_q      <= PTR_W'(NUM_Q - 1);
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            out_wr_q   <= '0;
            out_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            out_wr_q   <= out_wr_d;
            out_data_q <= out_data_d;
            err_q      <= err_d;
        end
    end

    assign out_wr   = out_wr_q;
    assign out_data = out_data_q;
    assign err      = err_q;
    assign idle     = !RESET_L || (all_empty && !pend_q);

endmodule : rr_arbiter
`default_nettype wire

// File: tb/tb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_arbiter
//  Purpose  : Self-checking bench for rr_arbiter. Upstream FIFOs are modelled
//             as queues; every pop pushes the expected downstream write into a
//             scoreboard that an independent monitor drains.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_arbiter;

    localparam int DW = 6;
    localparam int NQ = 4;

    logic               clk;
    logic               RESET_L;
    logic [NQ-1:0]      in_empty;
    logic [NQ*DW-1:0]   in_data;
    logic [NQ-1:0]      in_valid;
    logic [NQ-1:0]      in_rd;
    logic [NQ-1:0]      out_pause;
    logic [NQ-1:0]      out_full;
    logic [NQ-1:0]      out_wr;
    logic [DW-1:0]      out_data;
    logic               err;
    logic               idle;

    rr_arbiter #(
        .DATA_W (DW),
        .NUM_Q  (NQ)
    ) dut (
        .clk       (clk),
        .RESET_L   (RESET_L),
        .in_empty  (in_empty),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_rd     (in_rd),
        .out_pause (out_pause),
        .out_full  (out_full),
        .out_wr    (out_wr),
        .out_data  (out_data),
        .err       (err),
        .idle      (idle)
    );

    typedef struct {
        logic [DW-1:0] word;
        int            due;
        bit            drop;
    } exp_t;

    logic [DW-1:0] uq [NQ][$];      // contents of each upstream FIFO
    exp_t          sb [$];          // expected downstream writes, in order
    int            grant_log [$];
    int            grant_cyc_log [$];
    int            last_g;          // queue granted most recently
    bit            prev_live;
    logic [NQ-1:0] pres_valid;
    logic [NQ*DW-1:0] pres_data;
    logic [NQ-1:0] pause_v;
    logic [NQ-1:0] full_v;
    logic [NQ-1:0] inject_v;
    int            cyc       = 0;
    int            n_cmp     = 0;
    int            n_fail    = 0;
    int            wr_pulses = 0;
    exp_t          mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Next queue in round-robin order after the last grant that holds a word.
    function automatic int exp_grant();
        for (int i = 1; i <= NQ; i++) begin
            int q;
            q = (last_g + i) % NQ;
            if (!in_empty[q]) return q;
        end
        return -1;
    endfunction

    function automatic bit queues_busy();
        for (int i = 0; i < NQ; i++) begin
            if (uq[i].size() != 0) return 1'b1;
        end
        return (pres_valid != '0);
    endfunction

    task automatic drive();
        for (int i = 0; i < NQ; i++) in_empty[i] = (uq[i].size() == 0);
        in_valid  = pres_valid | inject_v;
        in_data   = pres_data;
        out_pause = pause_v;
        out_full  = full_v;
    endtask

    // Observe the pop strobe, check it, and emulate the upstream FIFO response.
    task automatic sample();
        bit            live;
        int            g;
        logic [DW-1:0] w;
        exp_t          e;
        if (!RESET_L) return;
        live = (pause_v == '0) && (in_empty != '1);
        if (pause_v != '0) check("rd_during_pause", int'(in_rd), 0);
        else if (prev_live && live) check("rd_when_eligible", int'(in_rd != '0), 1);
        pres_valid = '0;
        if (in_rd != '0) begin
            g = exp_grant();
            check("rr_grant", int'(in_rd), (g < 0) ? 0 : (1 << g));
            if (g >= 0 && in_rd[g]) begin
                w = uq[g].pop_front();
                pres_valid[g] = 1'b1;
                pres_data[g*DW +: DW] = w;
                e.word = w;
                e.due  = cyc + 2;
                e.drop = full_v[w[DW-1 -: 2]];
                sb.push_back(e);
                last_g = g;
                grant_log.push_back(g);
                grant_cyc_log.push_back(cyc);
            end
        end
        prev_live = live;
    endtask

    task automatic tick();
        drive();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic assert_reset();
        RESET_L = 1'b0;
        for (int i = 0; i < NQ; i++) uq[i].delete();
        sb.delete();
        grant_log.delete();
        grant_cyc_log.delete();
        pres_valid = '0;
        inject_v   = '0;
        pause_v    = '0;
        full_v     = '0;
        last_g     = NQ - 1;
        prev_live  = 1'b0;
        drive();
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        RESET_L = 1'b1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_in_rd"},    int'(in_rd),    0);
        check({tag, "_out_wr"},   int'(out_wr),   0);
        check({tag, "_out_data"}, int'(out_data), 0);
        check({tag, "_err"},      int'(err),      0);
        check({tag, "_idle"},     int'(idle),     1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((queues_busy() || sb.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        check({name, "_drained"}, int'(n < 200), 1);
        repeat (3) tick();
    endtask

    // Monitor: every downstream write must match the scoreboard head on its due cycle.
    always @(negedge clk) begin
        if (RESET_L) begin
            if (out_wr != '0) wr_pulses++;
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                mon_e = sb.pop_front();
                if (mon_e.drop) begin
                    check("dropped_word_wr", int'(out_wr), 0);
                end else begin
                    check("route_wr",   int'(out_wr),   1 << mon_e.word[DW-1 -: 2]);
                    check("route_data", int'(out_data), int'(mon_e.word));
                end
            end else begin
                check("no_spurious_wr", int'(out_wr), 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n0;
        int base;
        int q;
        pres_data = '0;
        RESET_L   = 1'b1;
        assert_reset();
        RESET_L   = 1'b1;
        drive();
        #2;
        // Initial reset: outputs must settle without any clock edge.
        assert_reset();
        #1;
        reset_checks("rst0");
        release_reset();

        // Fairness: two words in every queue -> 0,1,2,3,0,1,2,3 back to back.
        for (int i = 0; i < NQ; i++) begin
            for (int k = 0; k < 2; k++) uq[i].push_back(DW'((i << 4) | $urandom_range(15)));
        end
        n = 0;
        while (grant_log.size() < 8 && n < 30) begin
            tick();
            n++;
        end
        check("fair_grants_seen", int'(grant_log.size() >= 8), 1);
        if (grant_log.size() >= 8) begin
            for (int i = 0; i < 8; i++) check("fair_order", grant_log[i], i % NQ);
            check("fair_consecutive", grant_cyc_log[7] - grant_cyc_log[0], 7);
        end
        wait_drain("fair");
        check("fair_idle", int'(idle), 1);

        // Routing: 6'b01_0101 from queue 2 lands on downstream FIFO 1.
        grant_log.delete();
        uq[2].push_back(6'b010101);
        n = 0;
        while (grant_log.size() == 0 && n < 10) begin
            tick();
            n++;
        end
        check("route_grant_q", (grant_log.size() > 0) ? grant_log[0] : -1, 2);
        tick();
        check("route2_out_wr",   int'(out_wr),   4'b0010);
        check("route2_out_data", int'(out_data), 6'b010101);
        wait_drain("route");

        // Backpressure: pause stops pops immediately, at most two words still
        // drain out, and pops restart once the state sees pause low.
        for (int i = 0; i < NQ; i++) begin
            for (int k = 0; k < 6; k++) uq[i].push_back(DW'($urandom_range(63)));
        end
        repeat (3) tick();
        base    = wr_pulses;
        pause_v = 4'b0010;
        repeat (6) tick();
        check("bp_slack_le2", int'((wr_pulses - base) <= 2), 1);
        n0      = grant_log.size();
        pause_v = '0;
        repeat (2) tick();
        check("bp_resume", int'(grant_log.size() > n0), 1);
        wait_drain("bp");

        // Randomized traffic with random pause windows.
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(3) == 0) begin
                    q = $urandom_range(NQ - 1);
                    if (uq[q].size() < 8) uq[q].push_back(DW'($urandom_range(63)));
                end
            end
            if ($urandom_range(15) == 0) begin
                pause_v = ($urandom_range(2) == 0) ? NQ'($urandom_range(15)) : '0;
            end
            tick();
        end
        pause_v = '0;
        wait_drain("random");
        check("random_err_clear", int'(err), 0);

        // Overflow: destination 3 full -> word dropped and err latched; a word
        // for an unblocked destination still goes through.
        full_v = 4'b1000;
        uq[1].push_back(6'b111010);
        uq[3].push_back(6'b001111);
        wait_drain("ovf");
        check("ovf_err", int'(err), 1);
        repeat (5) tick();
        check("ovf_err_sticky", int'(err), 1);
        full_v = '0;

        // Protocol error: valid on queue 0 with nothing pending.
        assert_reset();
        release_reset();
        check("perr_err_cleared", int'(err), 0);
        repeat (2) tick();
        pres_data[DW-1:0] = 6'b000011;
        inject_v = 4'b0001;
        tick();
        inject_v = '0;
        check("perr_err", int'(err), 1);
        repeat (3) tick();
        check("perr_err_sticky", int'(err), 1);

        // Reset mid-stream: outputs clear at once and the in-flight word is lost.
        for (int i = 0; i < NQ; i++) begin
            for (int k = 0; k < 4; k++) uq[i].push_back(DW'($urandom_range(63)));
        end
        repeat (4) tick();
        #2;
        assert_reset();
        #1;
        reset_checks("rst_mid");
        release_reset();
        repeat (5) tick();
        check("rst_mid_idle_after", int'(idle), 1);
        check("rst_mid_err_after",  int'(err),  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_rr_arbiter
`default_nettype wire
